// File: rtl/ex_stage_mc.sv
// Execute stage with a valid/ready input handshake and a registered EX/MEM output.
// It computes single-cycle ALU operations, a DATA_W-cycle shift-add multiply, and
// can steer a result to a network-interface port with valid/ready backpressure.
module ex_stage_mc #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rd1_E,
  input  logic [DATA_W-1:0] rd2_E,
  input  logic [DATA_W-1:0] PC_E,
  input  logic [DATA_W-1:0] extend_out_E,
  input  logic              ALU_src_E,
  input  logic [3:0]        ALU_control_E,
  input  logic              alu_out_E,
  output logic              out_valid,
  output logic [DATA_W-1:0] ALU_result_M,
  output logic [DATA_W-1:0] Write_Data_M,
  output logic [DATA_W-1:0] next_PC_target_M,
  output logic              ZERO_M,
  output logic [DATA_W-1:0] NI_data,
  output logic              NI_valid,
  input  logic              NI_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, MUL, NI_WAIT} state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  mcand_reg, mcand_next;
  logic [DATA_W-1:0]  mplier_reg, mplier_next;
  logic [DATA_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               ni_sel_reg, ni_sel_next;
  logic [DATA_W-1:0]  wd_reg, wd_next;
  logic [DATA_W-1:0]  target_reg, target_next;
  logic [DATA_W-1:0]  alu_result_reg, alu_result_next;
  logic [DATA_W-1:0]  write_data_reg, write_data_next;
  logic [DATA_W-1:0]  next_pc_reg, next_pc_next;
  logic               zero_reg, zero_next;
  logic               out_valid_reg, out_valid_next;
  logic [DATA_W-1:0]  ni_data_reg, ni_data_next;
  logic               ni_valid_reg, ni_valid_next;

  logic [DATA_W-1:0]  src_b;
  logic [DATA_W-1:0]  alu_res;
  logic [DATA_W-1:0]  pc_sum;
  logic [DATA_W-1:0]  step_sum;

  assign src_b    = ALU_src_E ? extend_out_E : rd2_E;
  assign pc_sum   = PC_E + extend_out_E;
  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  assign step_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Single-cycle ALU on the live decode operands.
  always_comb begin
    alu_res = '0;
    case (ALU_control_E)
      4'b0000: alu_res = rd1_E & src_b;
      4'b0001: alu_res = rd1_E | src_b;
      4'b0010: alu_res = rd1_E + src_b;
      4'b0011: alu_res = rd1_E ^ src_b;
      4'b0100: alu_res = rd1_E << src_b[SHAMT_W-1:0];
      4'b0101: alu_res = rd1_E >> src_b[SHAMT_W-1:0];
      4'b0110: alu_res = rd1_E - src_b;
      4'b0111: alu_res = {{(DATA_W-1){1'b0}}, ($signed(rd1_E) < $signed(src_b))};
      4'b1001: alu_res = {{(DATA_W-1){1'b0}}, (rd1_E < src_b)};
      default: alu_res = '0;
    endcase
  end

  // Next-state and next-output logic for the IDLE / MUL / NI_WAIT controller.
  always_comb begin
    state_next      = state_reg;
    mcand_next      = mcand_reg;
    mplier_next     = mplier_reg;
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    ni_sel_next     = ni_sel_reg;
    wd_next         = wd_reg;
    target_next     = target_reg;
    alu_result_next = alu_result_reg;
    write_data_next = write_data_reg;
    next_pc_next    = next_pc_reg;
    zero_next       = zero_reg;
    out_valid_next  = 1'b0;
    ni_data_next    = ni_data_reg;
    ni_valid_next   = ni_valid_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          wd_next     = rd2_E;
          target_next = pc_sum;
          if (ALU_control_E == 4'b1000) begin
            mcand_next  = rd1_E;
            mplier_next = src_b;
            acc_next    = '0;
            cnt_next    = CNT_W'(DATA_W);
            ni_sel_next = alu_out_E;
            state_next  = MUL;
          end else if (alu_out_E) begin
            ni_data_next  = alu_res;
            ni_valid_next = 1'b1;
            state_next    = NI_WAIT;
          end else begin
            alu_result_next = alu_res;
            zero_next       = (alu_res == '0);
            write_data_next = rd2_E;
            next_pc_next    = pc_sum;
            out_valid_next  = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next    = step_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          if (ni_sel_reg) begin
            ni_data_next  = step_sum;
            ni_valid_next = 1'b1;
            state_next    = NI_WAIT;
          end else begin
            alu_result_next = step_sum;
            zero_next       = (step_sum == '0);
            write_data_next = wd_reg;
            next_pc_next    = target_reg;
            out_valid_next  = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      NI_WAIT: begin
        if (NI_ready) begin
          // The result went to the NI, so the pipeline sees a zero result.
          ni_valid_next   = 1'b0;
          alu_result_next = '0;
          zero_next       = 1'b1;
          write_data_next = wd_reg;
          next_pc_next    = target_reg;
          out_valid_next  = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      ni_sel_reg     <= 1'b0;
      wd_reg         <= '0;
      target_reg     <= '0;
      alu_result_reg <= '0;
      write_data_reg <= '0;
      next_pc_reg    <= '0;
      zero_reg       <= 1'b0;
      out_valid_reg  <= 1'b0;
      ni_data_reg    <= '0;
      ni_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mcand_reg      <= mcand_next;
      mplier_reg     <= mplier_next;
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      ni_sel_reg     <= ni_sel_next;
      wd_reg         <= wd_next;
      target_reg     <= target_next;
      alu_result_reg <= alu_result_next;
      write_data_reg <= write_data_next;
      next_pc_reg    <= next_pc_next;
      zero_reg       <= zero_next;
      out_valid_reg  <= out_valid_next;
      ni_data_reg    <= ni_data_next;
      ni_valid_reg   <= ni_valid_next;
    end
  end

  assign in_ready         = (state_reg == IDLE);
  assign busy             = (state_reg != IDLE);
  assign out_valid        = out_valid_reg;
  assign ALU_result_M     = alu_result_reg;
  assign Write_Data_M     = write_data_reg;
  assign next_PC_target_M = next_pc_reg;
  assign ZERO_M           = zero_reg;
  assign NI_data          = ni_data_reg;
  assign NI_valid         = ni_valid_reg;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: a table of single-cycle ALU vectors applied
// back-to-back, plus hand-written multiply, NI and reset sequences for both
// DATA_W=32 and DATA_W=16 instances.
module tb_ex_stage_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DATA_W = 32 instance signals
  logic        in_valid, in_ready, ALU_src_E, alu_out_E, out_valid, ZERO_M, NI_valid, NI_ready, busy;
  logic [31:0] rd1_E, rd2_E, PC_E, extend_out_E, ALU_result_M, Write_Data_M, next_PC_target_M, NI_data;
  logic [3:0]  ALU_control_E;

  // DATA_W = 16 instance signals
  logic        h_in_valid, h_in_ready, h_src, h_alu_out, h_out_valid, h_zero, h_ni_valid, h_ni_ready, h_busy;
  logic [15:0] h_rd1, h_rd2, h_pc, h_ext, h_res, h_wd, h_tgt, h_ni_data;
  logic [3:0]  h_ctl;

  ex_stage_mc #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rd1_E(rd1_E), .rd2_E(rd2_E), .PC_E(PC_E), .extend_out_E(extend_out_E),
    .ALU_src_E(ALU_src_E), .ALU_control_E(ALU_control_E), .alu_out_E(alu_out_E),
    .out_valid(out_valid), .ALU_result_M(ALU_result_M), .Write_Data_M(Write_Data_M),
    .next_PC_target_M(next_PC_target_M), .ZERO_M(ZERO_M), .NI_data(NI_data),
    .NI_valid(NI_valid), .NI_ready(NI_ready), .busy(busy)
  );

  ex_stage_mc #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .rd1_E(h_rd1), .rd2_E(h_rd2), .PC_E(h_pc), .extend_out_E(h_ext),
    .ALU_src_E(h_src), .ALU_control_E(h_ctl), .alu_out_E(h_alu_out),
    .out_valid(h_out_valid), .ALU_result_M(h_res), .Write_Data_M(h_wd),
    .next_PC_target_M(h_tgt), .ZERO_M(h_zero), .NI_data(h_ni_data),
    .NI_valid(h_ni_valid), .NI_ready(h_ni_ready), .busy(h_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, ext, pc;
    logic        src;
    logic [31:0] res;
    logic        zero;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] ext, input logic [31:0] pc, input logic src,
                              input logic [31:0] res, input logic zero, input logic [31:0] tgt);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ext = ext; v.pc = pc; v.src = src;
    v.res = res; v.zero = zero; v.tgt = tgt;
    return v;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ext, input logic [31:0] pc, input logic src, input logic ni);
    ALU_control_E = op; rd1_E = a; rd2_E = b; extend_out_E = ext; PC_E = pc;
    ALU_src_E = src; alu_out_E = ni;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int ir_low, ov_cnt, ov_k, ni_k;
  logic [31:0] cap_res, cap_ni;

  initial begin
    rst = 1'b1; in_valid = 1'b0; NI_ready = 1'b0;
    drive(4'h0, 0, 0, 0, 0, 1'b0, 1'b0);
    h_in_valid = 1'b0; h_ni_ready = 1'b0; h_src = 1'b0; h_alu_out = 1'b0;
    h_rd1 = '0; h_rd2 = '0; h_pc = '0; h_ext = '0; h_ctl = '0;

    //            op     a             b             ext           pc            src   res           z     tgt
    vecs[0]  = mk(4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0,        1'b0, 32'h80000000, 1'b0, 32'h0);
    vecs[1]  = mk(4'h6, 32'h00000005, 32'h00000033, 32'h5,        32'h100,      1'b1, 32'h0,        1'b1, 32'h105);
    vecs[2]  = mk(4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h4,        1'b0, 32'h1,        1'b0, 32'h4);
    vecs[3]  = mk(4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h8,        1'b0, 32'h0,        1'b1, 32'h8);
    vecs[4]  = mk(4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hC,        32'hC,        1'b0, 32'h00F000F0, 1'b0, 32'h18);
    vecs[5]  = mk(4'h1, 32'h000000A5, 32'h0000005A, 32'hFFFFFFFC, 32'h10,       1'b0, 32'h000000FF, 1'b0, 32'hC);
    vecs[6]  = mk(4'h3, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        32'h0,        1'b0, 32'hF0F00F0F, 1'b0, 32'h0);
    vecs[7]  = mk(4'h4, 32'h00000003, 32'h00000021, 32'h0,        32'h0,        1'b0, 32'h6,        1'b0, 32'h0);
    vecs[8]  = mk(4'h4, 32'h00000001, 32'h00000000, 32'h1F,       32'h20,       1'b1, 32'h80000000, 1'b0, 32'h3F);
    vecs[9]  = mk(4'h5, 32'h80000000, 32'h00000004, 32'h0,        32'h0,        1'b0, 32'h08000000, 1'b0, 32'h0);
    vecs[10] = mk(4'h6, 32'h00000000, 32'h00000001, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 32'h0);
    vecs[11] = mk(4'hF, 32'h00000123, 32'h00000456, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 32'h0);
    vecs[12] = mk(4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 32'h0);
    vecs[13] = mk(4'h9, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 32'h1,        1'b0, 32'h0);
    vecs[14] = mk(4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF);

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ni_valid", NI_valid, 0);
    chk("rst_result", ALU_result_M, 0);
    chk("rst_zero", ZERO_M, 0);
    chk("rst_target", next_PC_target_M, 0);
    chk("rst_wdata", Write_Data_M, 0);
    chk("rst_h_in_ready", h_in_ready, 1);

    // Back-to-back single-cycle vectors
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ext, vecs[i].pc, vecs[i].src, 1'b0);
      in_valid = 1'b1;
      step();
      $display("txn vec %0d op=%h a=%h b=%h -> result=%h zero=%b tgt=%h", i, vecs[i].op,
               vecs[i].a, vecs[i].b, ALU_result_M, ZERO_M, next_PC_target_M);
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), ALU_result_M, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), ZERO_M, vecs[i].zero);
      chk($sformatf("vec%0d_target", i), next_PC_target_M, vecs[i].tgt);
      chk($sformatf("vec%0d_wdata", i), Write_Data_M, vecs[i].b);
    end
    in_valid = 1'b0;
    step();
    chk("idle_out_valid_low", out_valid, 0);
    chk("idle_result_hold", ALU_result_M, 32'h0);
    chk("idle_target_hold", next_PC_target_M, 32'hFFFFFFFF);

    // MUL 0xFFFF x 0x10001 with in_valid pulses while busy
    drive(4'h8, 32'h0000FFFF, 32'h00010001, 32'h8, 32'h200, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ir_low = 0; ov_cnt = 0; ov_k = 0; cap_res = '0;
    chk("mul_busy", busy, 1);
    for (int k = 1; k <= 40; k++) begin
      in_valid = ((k % 3) == 0) && (k <= 30);
      if (!in_ready) ir_low++;
      if (out_valid) begin ov_cnt++; ov_k = k; cap_res = ALU_result_M; end
      if (k == 33) begin
        chk("mul_wdata", Write_Data_M, 32'h00010001);
        chk("mul_target", next_PC_target_M, 32'h208);
        chk("mul_zero", ZERO_M, 0);
      end
      step();
    end
    in_valid = 1'b0;
    $display("txn mul 0000ffff*00010001 -> result=%h at cycle %0d", cap_res, ov_k);
    chk("mul_in_ready_low_cycles", ir_low, 32);
    chk("mul_out_valid_count", ov_cnt, 1);
    chk("mul_out_valid_cycle", ov_k, 33);
    chk("mul_result", cap_res, 32'hFFFFFFFF);

    // NI routing with 5 cycles of backpressure
    drive(4'h1, 32'hA5, 32'h5A, 32'h4, 32'h300, 1'b0, 1'b1);
    NI_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      NI_ready = (k == 6);
      chk($sformatf("ni_valid_c%0d", k), NI_valid, 1);
      chk($sformatf("ni_data_c%0d", k), NI_data, 32'hFF);
      chk($sformatf("ni_out_valid_c%0d", k), out_valid, 0);
      chk($sformatf("ni_in_ready_c%0d", k), in_ready, 0);
      step();
    end
    NI_ready = 1'b0;
    $display("txn ni or a5|5a -> ni_data=ff, pipeline result=%h zero=%b", ALU_result_M, ZERO_M);
    chk("ni_done_out_valid", out_valid, 1);
    chk("ni_done_result", ALU_result_M, 0);
    chk("ni_done_zero", ZERO_M, 1);
    chk("ni_done_target", next_PC_target_M, 32'h304);
    chk("ni_done_wdata", Write_Data_M, 32'h5A);
    chk("ni_done_ni_valid", NI_valid, 0);
    chk("ni_done_in_ready", in_ready, 1);

    // NI minimum occupancy: NI_ready already high
    drive(4'h3, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0, 1'b1);
    NI_ready = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ni_min_valid", NI_valid, 1);
    chk("ni_min_data", NI_data, 32'hFF);
    step();
    NI_ready = 1'b0;
    $display("txn ni xor 0f^f0 fast handshake -> out_valid=%b in_ready=%b", out_valid, in_ready);
    chk("ni_min_out_valid", out_valid, 1);
    chk("ni_min_in_ready", in_ready, 1);

    // MUL routed to NI
    drive(4'h8, 32'h3, 32'h5, 32'h0, 32'h0, 1'b0, 1'b1);
    NI_ready = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ni_k = 0; ov_k = 0; cap_ni = '0;
    for (int k = 1; k <= 40; k++) begin
      if (NI_valid && ni_k == 0) begin ni_k = k; cap_ni = NI_data; end
      if (out_valid && ov_k == 0) ov_k = k;
      step();
    end
    NI_ready = 1'b0;
    $display("txn mul->ni 3*5 -> ni_data=%h at cycle %0d", cap_ni, ni_k);
    chk("mulni_valid_cycle", ni_k, 33);
    chk("mulni_data", cap_ni, 32'd15);
    chk("mulni_out_valid_cycle", ov_k, 34);

    // Reset in cycle 10 of a MUL
    drive(4'h8, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmul_out_valid", out_valid, 0);
    chk("rstmul_busy", busy, 0);
    chk("rstmul_in_ready", in_ready, 1);
    ov_cnt = 0;
    for (int k = 0; k < 35; k++) begin
      if (out_valid) ov_cnt++;
      step();
    end
    chk("rstmul_no_out_valid", ov_cnt, 0);
    drive(4'h2, 32'd2, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    $display("txn add 2+3 after reset -> result=%h", ALU_result_M);
    chk("rstmul_add_valid", out_valid, 1);
    chk("rstmul_add_result", ALU_result_M, 32'd5);

    // Reset during NI_WAIT drops NI_valid
    drive(4'h1, 32'h1, 32'h2, 32'h0, 32'h0, 1'b0, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rstni_pending", NI_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstni_ni_valid", NI_valid, 0);
    chk("rstni_out_valid", out_valid, 0);
    chk("rstni_in_ready", in_ready, 1);

    // DATA_W = 16: MUL 0x00FF x 0x0101
    h_ctl = 4'h8; h_rd1 = 16'h00FF; h_rd2 = 16'h0101; h_alu_out = 1'b0;
    h_in_valid = 1'b1;
    step();
    h_in_valid = 1'b0;
    ir_low = 0; ov_k = 0; cap_res = '0;
    for (int k = 1; k <= 20; k++) begin
      if (!h_in_ready) ir_low++;
      if (h_out_valid && ov_k == 0) begin ov_k = k; cap_res = {16'h0, h_res}; end
      step();
    end
    $display("txn w16 mul 00ff*0101 -> result=%h at cycle %0d", cap_res[15:0], ov_k);
    chk("w16_mul_cycle", ov_k, 17);
    chk("w16_mul_in_ready_low", ir_low, 16);
    chk("w16_mul_result", cap_res, 32'hFFFF);

    // DATA_W = 16: SLL by 17 uses shift amount 1
    h_ctl = 4'h4; h_rd1 = 16'h0001; h_rd2 = 16'd17;
    h_in_valid = 1'b1;
    step();
    h_in_valid = 1'b0;
    $display("txn w16 sll 1<<17 -> result=%h", h_res);
    chk("w16_sll_valid", h_out_valid, 1);
    chk("w16_sll_result", h_res, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised, registered successor to the MIPS execute stage. It computes ALU results for DATA_W-bit operands and adds an iterative multi-cycle multiplier. The stage has a valid/ready handshake toward decode and a registered EX/MEM output. Results marked for the network interface leave on a dedicated NI port with valid/ready backpressure instead of going down the pipeline.

## Interface
Parameters:
- DATA_W, 32, operand/result/PC width (≥8, power of two)
- SHAMT_W, $clog2(DATA_W), shift-amount bits taken from srcB LSBs

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts; transfer when in_valid & in_ready
- rd1_E, rd2_E  in  DATA_W  register operands
- PC_E  in  DATA_W  instruction PC
- extend_out_E  in  DATA_W  sign-extended immediate
- ALU_src_E  in  1  srcB = extend_out_E when 1, else rd2_E
- ALU_control_E  in  4  operation code
- alu_out_E  in  1  1 = route result to NI port, not pipeline
- out_valid  out  1  one-cycle pulse: EX/MEM registers hold a new instruction
- ALU_result_M  out  DATA_W  registered result
- Write_Data_M  out  DATA_W  registered rd2_E
- next_PC_target_M  out  DATA_W  registered PC_E + extend_out_E (mod 2^DATA_W)
- ZERO_M  out  1  registered (result == 0)
- NI_data  out  DATA_W  result for network interface
- NI_valid  out  1  NI_data valid; held until NI_ready
- NI_ready  in  1  NI accepts
- busy  out  1  state ≠ IDLE

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL (logical), 0110 SUB, 0111 SLT signed (result 1/0), 1001 SLTU, 1000 MUL. MUL gives the low DATA_W bits of the unsigned product, which equal the low bits of the signed product. Unlisted codes give result 0.
- Add/sub wrap modulo 2^DATA_W; no overflow flag. Shifts use srcB[SHAMT_W-1:0].
- FSM states:
  - IDLE: in_ready=1. On accept of a non-MUL op with alu_out_E=0: register all outputs, out_valid=1 next cycle, stay IDLE. On accept of MUL: latch operands, counter=DATA_W, go to MUL. On accept of a non-MUL op with alu_out_E=1: load NI_data, NI_valid=1, go to NI_WAIT.
  - MUL: shift-add, one multiplier bit per cycle, counter decrements. At counter==1 the final step completes. If the latched alu_out=0, register outputs, pulse out_valid and go to IDLE. If alu_out=1, load NI_data, go to NI_WAIT.
  - NI_WAIT: NI_valid=1 and NI_data stable. When NI_ready=1: NI_valid=0 next cycle, out_valid pulses with ALU_result_M=0, ZERO_M=1, Write_Data_M and next_PC_target_M updated, return to IDLE.
- in_ready=0 in MUL and NI_WAIT. in_valid during those states is ignored, and decode must hold its inputs.
- PC_E, rd2_E and extend_out_E are captured at accept. next_PC_target_M and Write_Data_M always reflect the accepted instruction.
- Reset:
  - Values: state=IDLE, all outputs 0, out_valid=0, NI_valid=0, busy=0, in_ready=1 from the cycle after the reset edge.
  - Reset mid-MUL or mid-NI_WAIT aborts the operation with no out_valid pulse; any pending NI_valid drops.
  - Reset has priority over every handshake in the same cycle.

## Timing
- Single-cycle op accepted at edge N: outputs valid and out_valid=1 during cycle N+1. Back-to-back accepts give out_valid every cycle.
- MUL accepted at edge N: busy from N+1, out_valid (or NI_valid) asserted during cycle N+DATA_W+1. in_ready is 0 for exactly DATA_W cycles, and the next accept can occur at edge N+DATA_W+1.
- NI path, non-MUL: NI_valid rises in cycle N+1. If NI_ready is 1 in that cycle, the transfer completes at edge N+1, with out_valid in N+2 and in_ready back to 1 in N+2. Minimum occupancy is 2 cycles.
- NI_data must not change while NI_valid=1 and NI_ready=0.
- out_valid is never asserted for two cycles on one instruction. Outputs hold their last value when out_valid=0.

## Test plan
- ADD rd1=0x7FFFFFFF, rd2=1, ALU_src=0 → cycle N+1: ALU_result_M=0x80000000, ZERO_M=0, out_valid=1 for one cycle.
- SUB 5−5 with ALU_src=1, extend_out=5, PC_E=0x100 → ALU_result_M=0, ZERO_M=1, next_PC_target_M=0x105. Also SLT −1<1 → 1 and SLTU 0xFFFFFFFF<1 → 0.
- MUL 0xFFFF×0x10001 (DATA_W=32) → in_ready low exactly 32 cycles, ALU_result_M=0xFFFFFFFF at N+33. in_valid pulses during busy cause no extra out_valid.
- NI routing: OR 0xA5 | 0x5A with alu_out_E=1 and NI_ready low for 5 cycles → NI_valid=1, NI_data=0xFF stable 6 cycles. After the handshake: out_valid=1, ALU_result_M=0.
- Reset asserted at cycle 10 of a MUL → no out_valid, busy=0 and in_ready=1 next cycle. A following ADD 2+3 yields 5 one cycle after accept.
- Parameter sweep DATA_W=16: MUL 0x00FF×0x0101 → 0xFFFF after 17 cycles. SLL by 17 uses shamt 1 (srcB[3:0]).
